// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default timing constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int CLKS_PER_TICK_115200 = 54;
  localparam int OVERSAMPLE           = 16;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - oversample tick generator, restartable so ticks align to a start edge
module uart_rx_tick_gen #(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CW      = $clog2(CLKS_PER_TICK);
  localparam logic [CW-1:0]   LP_TERM = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LP_TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver; UART_RX_PARITY_EN adds a parity bit and parity_err
module uart_rx_oversampled #(
  parameter int CLKS_PER_TICK = uart_pkg::CLKS_PER_TICK_115200,
  parameter int OVERSAMPLE    = uart_pkg::OVERSAMPLE,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  import uart_pkg::*;

  if (CLKS_PER_TICK < 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_oversampled: illegal parameter set");
  end

  localparam int            TW          = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LP_MID      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LP_LAST     = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LP_LAST_BIT = 4'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_tick_clr;
  logic                 w_bit_end;
  uart_rx_state_t       r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
`endif

  // Sync flops preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  assign w_rx_s     = r_sync[1];
  assign w_tick_clr = (r_state == IDLE) && !w_rx_s;
  assign w_bit_end  = w_tick && (r_tick_cnt == LP_LAST);

  uart_rx_tick_gen #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (w_tick_clr),
    .tick(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (w_tick && r_state != IDLE && r_state != BREAK)
        r_tick_cnt <= (r_tick_cnt == LP_LAST) ? '0 : r_tick_cnt + 1'b1;

      case (r_state)
        IDLE: if (!w_rx_s) begin
          r_tick_cnt <= '0;
          busy       <= 1'b1;
          r_state    <= START;
        end
        // Mid-start check rejects glitches shorter than half a bit.
        START: if (w_tick && r_tick_cnt == LP_MID) begin
          r_tick_cnt <= '0;
          if (w_rx_s) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_bit_idx <= '0;
            r_state   <= DATA;
          end
        end
        DATA: if (w_bit_end) begin
          r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
          r_bit_idx <= r_bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_idx == LP_LAST_BIT) r_state <= PARITY;
`else
          if (r_bit_idx == LP_LAST_BIT) r_state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_bit_end) begin
          r_par_bad <= (^r_shift) ^ w_rx_s ^ PARITY_ODD[0];
          r_state   <= STOP;
        end
`endif
        STOP: if (w_bit_end) begin
          if (w_rx_s) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err <= r_par_bad;
`endif
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            frame_err <= 1'b1;
            r_state   <= BREAK;
          end
        end
        BREAK: if (w_rx_s) begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
